// File: rtl/cpu_pkg.sv
// Shared definitions for the single-clock 6502-subset core:
// opcodes, FSM states, ALU operations and status-register layout.
package cpu_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_SBC_IMM = 8'hE9;
    localparam logic [7:0] OP_AND_IMM = 8'h29;
    localparam logic [7:0] OP_ORA_IMM = 8'h09;
    localparam logic [7:0] OP_EOR_IMM = 8'h49;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_OPER  = 2'd1,
        ST_JHI   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ALU_SUM = 2'd0,
        ALU_AND = 2'd1,
        ALU_OR  = 2'd2,
        ALU_EOR = 2'd3
    } alu_op_t;

    // Status layout {N,V,1,0,0,0,Z,C}; bit 5 is hard-wired high.
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] P_RESET  = 8'h20;
    localparam logic [7:0] IR_RESET = OP_NOP;

    function automatic logic isImmediate(input logic [7:0] op);
        return (op == OP_LDA_IMM) || (op == OP_ADC_IMM) || (op == OP_SBC_IMM) ||
               (op == OP_AND_IMM) || (op == OP_ORA_IMM) || (op == OP_EOR_IMM);
    endfunction

endpackage

// File: rtl/cpu_core_seq_if.sv
// Memory-read and debug/trace bundle of the core; master is the CPU,
// slave is the memory map / trace side.
interface cpu_core_seq_if #(
    parameter int DW = 8,
    parameter int AW = 2 * DW
);
    logic          rdy;
    logic [DW-1:0] data_in;
    logic [AW-1:0] addr;
    logic          rd_en;
    logic [DW-1:0] ac_out;
    logic [7:0]    p_out;
    logic [AW-1:0] pc_out;
    logic [7:0]    ir_out;
    logic [1:0]    state_out;
    logic          illegal;

    modport master (
        input  rdy, data_in,
        output addr, rd_en, ac_out, p_out, pc_out, ir_out, state_out, illegal
    );

    modport slave (
        output rdy, data_in,
        input  addr, rd_en, ac_out, p_out, pc_out, ir_out, state_out, illegal
    );
endinterface

// File: rtl/cpu_core_seq_alu.sv
// Combinational DW-bit ALU: add with carry (optionally on an inverted
// operand for subtraction) plus the three bitwise logic operations.
module alu_param
    import cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_cin,
    input  alu_op_t       i_op,
    input  logic          i_invB,
    output logic [DW-1:0] o_res,
    output logic          o_cout,
    output logic          o_ovf
);

    logic [DW-1:0] w_b;
    logic [DW:0]   w_sum;

    // Overflow is judged on the post-inversion operand so SBC reuses the adder.
    always_comb begin
        w_b    = i_invB ? ~i_b : i_b;
        w_sum  = {1'b0, i_a} + {1'b0, w_b} + {{DW{1'b0}}, i_cin};
        o_cout = w_sum[DW];
        o_ovf  = (i_a[DW-1] == w_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
        case (i_op)
            ALU_AND: o_res = i_a & w_b;
            ALU_OR:  o_res = i_a | w_b;
            ALU_EOR: o_res = i_a ^ w_b;
            default: o_res = w_sum[DW-1:0];
        endcase
    end

endmodule

// File: rtl/cpu_core_seq.sv
// Single-clock 6502-subset core: FETCH/OPER/JHI sequencer, PC, A/P/IR
// registers and decode, stallable with rdy.
module cpu_core_seq
    import cpu_pkg::*;
#(
    parameter int            DW       = 8,
    parameter int            AW       = 2 * DW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic              clk_ph1,
    input  logic              rst,
    cpu_core_seq_if.master    bus
);

    state_t        r_state;
    state_t        w_stateNext;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pcNext;
    logic [AW-1:0] w_pcInc;
    logic [7:0]    r_ir;
    logic [7:0]    w_irNext;
    logic [DW-1:0] r_ac;
    logic [DW-1:0] w_acNext;
    logic [7:0]    r_p;
    logic [7:0]    w_pNext;
    logic [DW-1:0] r_lo;
    logic [DW-1:0] w_loNext;
    logic          r_illegal;
    logic          w_illegalNext;
    logic          w_setNz;

    alu_op_t       w_aluOp;
    logic          w_aluInvB;
    logic [DW-1:0] w_aluRes;
    logic          w_aluCout;
    logic          w_aluOvf;

    alu_param #(.DW(DW)) u_alu (
        .i_a    (r_ac),
        .i_b    (bus.data_in),
        .i_cin  (r_p[P_C]),
        .i_op   (w_aluOp),
        .i_invB (w_aluInvB),
        .o_res  (w_aluRes),
        .o_cout (w_aluCout),
        .o_ovf  (w_aluOvf)
    );

    assign w_pcInc = r_pc + {{(AW-1){1'b0}}, 1'b1};

    // The address always comes from registered PC, so data_in never reaches addr.
    assign bus.addr      = r_pc;
    assign bus.rd_en     = rst;
    assign bus.ac_out    = r_ac;
    assign bus.p_out     = r_p;
    assign bus.pc_out    = r_pc;
    assign bus.ir_out    = r_ir;
    assign bus.state_out = r_state;
    assign bus.illegal   = r_illegal;

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else if (bus.rdy) begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= IR_RESET;
            r_ac      <= '0;
            r_p       <= P_RESET;
            r_lo      <= '0;
            r_illegal <= 1'b0;
        end else if (bus.rdy) begin
            r_pc      <= w_pcNext;
            r_ir      <= w_irNext;
            r_ac      <= w_acNext;
            r_p       <= w_pNext;
            r_lo      <= w_loNext;
            r_illegal <= w_illegalNext;
        end
    end

    // Decode and next-state; implied and undefined ops leave PC alone (dummy read).
    always_comb begin
        w_stateNext   = r_state;
        w_pcNext      = r_pc;
        w_irNext      = r_ir;
        w_acNext      = r_ac;
        w_pNext       = r_p;
        w_loNext      = r_lo;
        w_illegalNext = r_illegal;
        w_setNz       = 1'b0;
        w_aluOp       = ALU_SUM;
        w_aluInvB     = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_irNext    = bus.data_in[7:0];
                w_pcNext    = w_pcInc;
                w_stateNext = ST_OPER;
            end

            ST_OPER: begin
                w_stateNext = ST_FETCH;
                if (isImmediate(r_ir)) begin
                    w_pcNext = w_pcInc;
                    w_setNz  = 1'b1;
                end
                case (r_ir)
                    OP_LDA_IMM: w_acNext = bus.data_in;
                    OP_ADC_IMM, OP_SBC_IMM: begin
                        w_aluInvB      = (r_ir == OP_SBC_IMM);
                        w_acNext       = w_aluRes;
                        w_pNext[P_C]   = w_aluCout;
                        w_pNext[P_V]   = w_aluOvf;
                    end
                    OP_AND_IMM: begin
                        w_aluOp  = ALU_AND;
                        w_acNext = w_aluRes;
                    end
                    OP_ORA_IMM: begin
                        w_aluOp  = ALU_OR;
                        w_acNext = w_aluRes;
                    end
                    OP_EOR_IMM: begin
                        w_aluOp  = ALU_EOR;
                        w_acNext = w_aluRes;
                    end
                    OP_CLC:     w_pNext[P_C] = 1'b0;
                    OP_SEC:     w_pNext[P_C] = 1'b1;
                    OP_NOP:     ;
                    OP_JMP_ABS: begin
                        w_loNext    = bus.data_in;
                        w_pcNext    = w_pcInc;
                        w_stateNext = ST_JHI;
                    end
                    default:    w_illegalNext = 1'b1;
                endcase
                if (w_setNz) begin
                    w_pNext[P_N] = w_acNext[DW-1];
                    w_pNext[P_Z] = (w_acNext == '0);
                end
            end

            ST_JHI: begin
                w_pcNext    = {bus.data_in, r_lo};
                w_stateNext = ST_FETCH;
            end

            default: w_stateNext = ST_FETCH;
        endcase
    end

endmodule
